gpio_port: RTL and testbench
============================

Name: gpio_port

Overview:
- Parametrised general-purpose I/O port, the next generation of the fixed 8-bit PORTB output latch.
- Provides AVR-style PORT/DDR/PIN registers on a small memory-mapped register interface driven by the RISC-V load/store unit.
- Adds a two-flop input synchroniser, a write-to-PIN output toggle and optional pin-change interrupt flags.
- Sits between the data-memory bus decode and the FPGA board pins; one instance per Arduino port (B, C, D).

Parameters:
- WIDTH, 8, number of pins in the port (1..32).
- SYNC_STAGES, 2, synchroniser flop depth on pin_in (minimum 2).

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- addr  input  3  register select: 0 PIN, 1 DDR, 2 PORT, 3 PCMSK, 4 PCIF; 5..7 reserved.
- wr_en  input  1  register write strobe, one cycle per write.
- wr_data  input  WIDTH  write data.
- rd_en  input  1  register read strobe.
- rd_data  output  WIDTH  registered read data.
- pin_in  input  WIDTH  asynchronous board pin levels.
- pin_out  output  WIDTH  output drive value, equal to PORT.
- pin_oe  output  WIDTH  output enable per pin, equal to DDR (1 = drive).
- irq  output  1  pin-change interrupt request, level.

Behaviour:
- Reset (asynchronous): DDR, PORT, PCMSK, PCIF, rd_data, all synchroniser flops and the edge-history register go to 0. As a result, pin_out, pin_oe and irq are 0.
- pin_out and pin_oe are driven directly from the PORT and DDR registers, so a write is visible on the pins the cycle after wr_en.
- Input path: pin_in passes through SYNC_STAGES flops to give pin_sync. The PIN value is pin_sync.
  - Latency from a pin_in change to a PIN read value is SYNC_STAGES cycles.
- Writes (wr_en high) take effect at the rising clock edge:
  - addr 0 (PIN): PORT <= PORT ^ wr_data, toggling the bits written as 1.
  - addr 1: DDR <= wr_data.
  - addr 2: PORT <= wr_data.
  - addr 3: PCMSK <= wr_data.
  - addr 4: write-1-to-clear; PCIF <= PCIF & ~wr_data.
  - Reserved addresses: the write is ignored.
- Reads: when rd_en is high, rd_data <= the selected register at the next edge. Reserved addresses read 0.
  - rd_data holds its value while rd_en is low.
  - PIN reads return pin_sync for every bit, including bits configured as outputs.
- Simultaneous wr_en and rd_en to the same register: the read returns the pre-write value.
- Edge detect: prev <= pin_sync every cycle. change = pin_sync ^ prev.
  - PCIF[i] is set when change[i] and PCMSK[i] are both 1.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- irq = |(PCIF). It stays asserted until software clears every flag.
- Pins configured as outputs still generate flags if masked; pad loop-back is intentional.
- Reset mid-operation: all state clears immediately. No pending writes survive reset.

Optional Feature:
- Macro: GPIO_PORT_PCINT_EN.
- Defined: the PCMSK/PCIF registers, edge-history register and irq logic are implemented as described above.
- Undefined: that logic is not built. addr 3 and 4 become reserved (writes ignored, reads return 0) and irq is tied to 0. PORT, DDR and PIN behaviour is unchanged.

Decomposition:
- Shared package gpio_pkg holds:
  - register address constants: GPIO_ADDR_PIN=3'd0, GPIO_ADDR_DDR=3'd1, GPIO_ADDR_PORT=3'd2, GPIO_ADDR_PCMSK=3'd3, GPIO_ADDR_PCIF=3'd4;
  - GPIO_ADDR_W=3.
- One sub-module: gpio_sync, a parametrised WIDTH x SYNC_STAGES flop chain with asynchronous reset, reusable by other input ports.

Test Plan:
- Reset/defaults: assert reset mid-run after writing DDR=8'hFF and PORT=8'hA5 -> pin_oe=0, pin_out=0, irq=0 immediately; reads of all registers return 0.
- Write/drive: write DDR=8'h0F then PORT=8'h3C -> pin_oe=8'h0F and pin_out=8'h3C on the next cycle; read PORT returns 8'h3C one cycle after rd_en.
- Toggle: with PORT=8'h3C, write PIN=8'h81 -> PORT=8'hBD; write PIN=8'h81 again -> PORT=8'h3C.
- Synchroniser latency: step pin_in 8'h00 to 8'h55 -> PIN read issued at SYNC_STAGES=2 cycles after the step returns 8'h55; a read issued one cycle earlier returns 8'h00.
- Pin change (macro defined): PCMSK=8'h01, toggle pin_in[0] and pin_in[1] -> PCIF=8'h01 and irq=1; W1C 8'h01 -> irq=0. Repeat with W1C coinciding with a new edge on bit 0 -> PCIF[0] stays 1.
- Macro undefined: write addr 3 with 8'hFF and toggle pins -> irq stays 0; reads of addr 3 and 4 return 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared register map for the GPIO port family (PIN/DDR/PORT plus pin-change registers).
package gpio_pkg;

    localparam int GPIO_ADDR_W = 3;

    typedef logic [GPIO_ADDR_W-1:0] gpio_addr_t;

    localparam gpio_addr_t GPIO_ADDR_PIN   = 3'd0;
    localparam gpio_addr_t GPIO_ADDR_DDR   = 3'd1;
    localparam gpio_addr_t GPIO_ADDR_PORT  = 3'd2;
    localparam gpio_addr_t GPIO_ADDR_PCMSK = 3'd3;
    localparam gpio_addr_t GPIO_ADDR_PCIF  = 3'd4;

endpackage

// File: rtl/gpio_sync.sv
// WIDTH x STAGES flop chain bringing asynchronous pin levels into the clock domain.
module gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_sync
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= pin_in;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign pin_sync = r_stage[STAGES-1];

endmodule

// File: rtl/gpio_port.sv
// AVR-style GPIO port: PORT/DDR/PIN registers, PIN-write toggle, synchronised inputs.
// Pin-change flags (PCMSK/PCIF/irq) are built only when GPIO_PORT_PCINT_EN is defined.
module gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [GPIO_ADDR_W-1:0] addr,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    input  logic [WIDTH-1:0]       pin_in,
    output logic [WIDTH-1:0]       pin_out,
    output logic [WIDTH-1:0]       pin_oe,
    output logic                   irq
);

    logic [WIDTH-1:0] r_ddr;
    logic [WIDTH-1:0] r_port;
    logic [WIDTH-1:0] r_rd_data;
    logic [WIDTH-1:0] w_pin_sync;
    logic [WIDTH-1:0] w_rd_mux;

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .pin_in   (pin_in),
        .pin_sync (w_pin_sync)
    );

    // A write to PIN toggles PORT rather than touching the (read-only) input value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ddr  <= '0;
            r_port <= '0;
        end else if (wr_en) begin
            case (addr)
                GPIO_ADDR_PIN:  r_port <= r_port ^ wr_data;
                GPIO_ADDR_DDR:  r_ddr  <= wr_data;
                GPIO_ADDR_PORT: r_port <= wr_data;
                default: ;
            endcase
        end
    end

`ifdef GPIO_PORT_PCINT_EN
    logic [WIDTH-1:0] r_pcmsk;
    logic [WIDTH-1:0] r_pcif;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;

    assign w_set = (w_pin_sync ^ r_prev) & r_pcmsk;
    assign w_clr = (wr_en && (addr == GPIO_ADDR_PCIF)) ? wr_data : '0;

    // Clear is applied before set so a fresh edge beats a coincident W1C.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pcmsk <= '0;
            r_pcif  <= '0;
            r_prev  <= '0;
        end else begin
            r_prev <= w_pin_sync;
            r_pcif <= (r_pcif & ~w_clr) | w_set;
            if (wr_en && (addr == GPIO_ADDR_PCMSK)) begin
                r_pcmsk <= wr_data;
            end
        end
    end

    assign irq = |r_pcif;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        w_rd_mux = '0;
        case (addr)
            GPIO_ADDR_PIN:   w_rd_mux = w_pin_sync;
            GPIO_ADDR_DDR:   w_rd_mux = r_ddr;
            GPIO_ADDR_PORT:  w_rd_mux = r_port;
`ifdef GPIO_PORT_PCINT_EN
            GPIO_ADDR_PCMSK: w_rd_mux = r_pcmsk;
            GPIO_ADDR_PCIF:  w_rd_mux = r_pcif;
`endif
            default:         w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign rd_data = r_rd_data;
    assign pin_out = r_port;
    assign pin_oe  = r_ddr;

endmodule

// File: tb/tb_gpio_port.sv
// Randomised self-checking bench for gpio_port against a register-level reference model.
module tb_gpio_port;

    localparam int W = 8;
    localparam int S = 2;
`ifdef GPIO_PORT_PCINT_EN
    localparam bit PCINT = 1'b1;
`else
    localparam bit PCINT = 1'b0;
`endif

    logic         clock   = 1'b0;
    logic         reset   = 1'b1;
    logic [2:0]   addr    = 3'd0;
    logic         wr_en   = 1'b0;
    logic         rd_en   = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic [W-1:0] pin_in  = '0;
    logic [W-1:0] rd_data;
    logic [W-1:0] pin_out;
    logic [W-1:0] pin_oe;
    logic         irq;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [W-1:0] m_ddr, m_port, m_pcmsk, m_pcif, m_prev, m_rd;
    logic [W-1:0] m_sq[$];

    gpio_port #(
        .WIDTH       (W),
        .SYNC_STAGES (S)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .addr    (addr),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .pin_in  (pin_in),
        .pin_out (pin_out),
        .pin_oe  (pin_oe),
        .irq     (irq)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_ddr = '0; m_port = '0; m_pcmsk = '0; m_pcif = '0; m_prev = '0; m_rd = '0;
        m_sq.delete();
        for (int i = 0; i < S; i++) m_sq.push_back('0);
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        logic [W-1:0] sync_now, sel, set_v, clr_v, nf;
        sync_now = m_sq[0];
        case (addr)
            3'd0: sel = sync_now;
            3'd1: sel = m_ddr;
            3'd2: sel = m_port;
            3'd3: sel = PCINT ? m_pcmsk : '0;
            3'd4: sel = PCINT ? m_pcif : '0;
            default: sel = '0;
        endcase
        set_v = PCINT ? ((sync_now ^ m_prev) & m_pcmsk) : '0;
        clr_v = (wr_en && addr == 3'd4) ? wr_data : '0;
        for (int i = 0; i < W; i++) begin
            if (set_v[i])      nf[i] = 1'b1;
            else if (clr_v[i]) nf[i] = 1'b0;
            else               nf[i] = m_pcif[i];
        end
        if (rd_en) m_rd = sel;
        if (wr_en) begin
            case (addr)
                3'd0: m_port = m_port ^ wr_data;
                3'd1: m_ddr  = wr_data;
                3'd2: m_port = wr_data;
                3'd3: if (PCINT) m_pcmsk = wr_data;
                default: ;
            endcase
        end
        if (PCINT) m_pcif = nf;
        m_prev = sync_now;
        void'(m_sq.pop_front());
        m_sq.push_back(pin_in);
    endtask

    // Drive one cycle of stimulus; returns 1 time unit after the edge.
    task automatic step(input logic w, input logic r, input logic [2:0] a,
                        input logic [W-1:0] d, input logic [W-1:0] pin);
        wr_en = w; rd_en = r; addr = a; wr_data = d; pin_in = pin;
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        n_vec++; if (pin_out !== '0 || pin_oe !== '0 || irq !== 1'b0 || rd_data !== '0) begin
            n_err++; $display("FAIL reset_initial: out=%h oe=%h irq=%b rd=%h required all 0", pin_out, pin_oe, irq, rd_data);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        step(1, 0, 3'd1, 8'hFF, '0);
        step(1, 0, 3'd2, 8'hA5, '0);
        step(1, 0, 3'd3, 8'hFF, '0);
        step(0, 1, 3'd2, '0, 8'h0F);
        n_vec++; if (pin_oe !== 8'hFF || pin_out !== 8'hA5) begin
            n_err++; $display("FAIL reset_prewrite: oe=%h out=%h required ff a5", pin_oe, pin_out);
        end
        wr_en = 0; rd_en = 0; pin_in = '0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_vec++; if (pin_oe !== '0 || pin_out !== '0 || irq !== 1'b0 || rd_data !== '0) begin
            n_err++; $display("FAIL reset_async: oe=%h out=%h irq=%b rd=%h required all 0", pin_oe, pin_out, irq, rd_data);
        end
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        for (int a = 0; a < 5; a++) begin
            step(0, 1, a[2:0], '0, '0);
            n_vec++; if (rd_data !== '0 || rd_data !== m_rd) begin
                n_err++; $display("FAIL reset_read_%0d: rd=%h required 00", a, rd_data);
            end
        end
    endtask

    task automatic test_write_drive();
        step(1, 0, 3'd1, 8'h0F, '0);
        step(1, 0, 3'd2, 8'h3C, '0);
        n_vec++; if (pin_oe !== 8'h0F || pin_oe !== m_ddr) begin
            n_err++; $display("FAIL drive_oe: got %h required 0f", pin_oe);
        end
        n_vec++; if (pin_out !== 8'h3C || pin_out !== m_port) begin
            n_err++; $display("FAIL drive_out: got %h required 3c", pin_out);
        end
        step(0, 1, 3'd2, '0, '0);
        n_vec++; if (rd_data !== 8'h3C || rd_data !== m_rd) begin
            n_err++; $display("FAIL drive_read_port: got %h required 3c", rd_data);
        end
        step(0, 0, 3'd1, 8'hFF, '0);
        n_vec++; if (rd_data !== 8'h3C) begin
            n_err++; $display("FAIL drive_rd_hold: got %h required 3c", rd_data);
        end
    endtask

    task automatic test_toggle();
        step(1, 0, 3'd0, 8'h81, '0);
        n_vec++; if (pin_out !== 8'hBD || pin_out !== m_port) begin
            n_err++; $display("FAIL toggle_1: got %h required bd", pin_out);
        end
        step(1, 0, 3'd0, 8'h81, '0);
        n_vec++; if (pin_out !== 8'h3C || pin_out !== m_port) begin
            n_err++; $display("FAIL toggle_2: got %h required 3c", pin_out);
        end
    endtask

    task automatic test_sync_latency();
        for (int i = 0; i < S + 2; i++) step(0, 0, 3'd0, '0, 8'h00);
        step(0, 0, 3'd0, '0, 8'h55);
        for (int i = 0; i < S - 2; i++) step(0, 0, 3'd0, '0, 8'h55);
        step(0, 1, 3'd0, '0, 8'h55);
        n_vec++; if (rd_data !== 8'h00 || rd_data !== m_rd) begin
            n_err++; $display("FAIL sync_early: got %h required 00", rd_data);
        end
        step(0, 1, 3'd0, '0, 8'h55);
        n_vec++; if (rd_data !== 8'h55 || rd_data !== m_rd) begin
            n_err++; $display("FAIL sync_on_time: got %h required 55", rd_data);
        end
    endtask

    task automatic test_pin_change();
        logic [W-1:0] p;
        p = pin_in;
        step(1, 0, 3'd3, 8'h01, p);
        p = p ^ 8'h03;
        step(0, 0, 3'd0, '0, p);
        for (int i = 0; i < S + 1; i++) step(0, 0, 3'd0, '0, p);
        n_vec++; if (irq !== PCINT || irq !== (|m_pcif)) begin
            n_err++; $display("FAIL pc_irq_set: got %b required %b", irq, PCINT);
        end
        step(0, 1, 3'd4, '0, p);
        n_vec++; if (rd_data !== (PCINT ? 8'h01 : 8'h00) || rd_data !== m_rd) begin
            n_err++; $display("FAIL pc_flag: got %h required %h", rd_data, PCINT ? 8'h01 : 8'h00);
        end
        step(0, 1, 3'd3, '0, p);
        n_vec++; if (rd_data !== (PCINT ? 8'h01 : 8'h00) || rd_data !== m_rd) begin
            n_err++; $display("FAIL pc_mask_read: got %h required %h", rd_data, PCINT ? 8'h01 : 8'h00);
        end
        step(1, 0, 3'd4, 8'h01, p);
        n_vec++; if (irq !== 1'b0 || irq !== (|m_pcif)) begin
            n_err++; $display("FAIL pc_w1c: irq=%b required 0", irq);
        end
        // New edge on bit 0 lands on the same cycle as a W1C of that bit
        p = p ^ 8'h01;
        step(0, 0, 3'd0, '0, p);
        for (int i = 0; i < S - 1; i++) step(0, 0, 3'd0, '0, p);
        step(1, 1, 3'd4, 8'h01, p);
        n_vec++; if (irq !== PCINT || irq !== (|m_pcif)) begin
            n_err++; $display("FAIL pc_set_wins_irq: got %b required %b", irq, PCINT);
        end
        step(0, 1, 3'd4, '0, p);
        n_vec++; if (rd_data !== (PCINT ? 8'h01 : 8'h00) || rd_data !== m_rd) begin
            n_err++; $display("FAIL pc_set_wins_flag: got %h required %h", rd_data, PCINT ? 8'h01 : 8'h00);
        end
        step(1, 0, 3'd4, 8'hFF, p);
    endtask

    task automatic test_random();
        logic [W-1:0] p;
        logic w, r;
        logic [2:0] a;
        p = pin_in;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) p = W'($urandom);
            a = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            step(w, r, a, W'($urandom), p);
            n_vec++; if (pin_out !== m_port || pin_oe !== m_ddr || irq !== (PCINT && (|m_pcif)) || rd_data !== m_rd) begin
                n_err++;
                $display("FAIL random_%0d: out=%h oe=%h irq=%b rd=%h required %h %h %b %h",
                         n, pin_out, pin_oe, irq, rd_data, m_port, m_ddr, PCINT && (|m_pcif), m_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_drive();
        test_toggle();
        test_sync_latency();
        test_pin_change();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
